// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: NOP encoding, default reset PC and the IF/ID register layout.
package rv32i_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        fault;
    } ifid_t;

    // Reset value and redirect bubble share one encoding.
    localparam ifid_t IFID_BUBBLE = '{
        valid:    1'b0,
        instr:    NOP,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        fault:    1'b0
    };

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with priority next-PC selection: reset, redirect, stall, then sequential +4.
// Alignment of redirect targets depends on FETCH_MISALIGN_TRAP_EN.
module fetch_pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] r_pc;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets are kept so the IF/ID capture can flag them.
    assign w_target = redirect_pc_i;
`else
    assign w_target = redirect_pc_i & ~32'h0000_0003;
`endif

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (redirect_valid_i) begin
            w_pc_next = w_target;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_o       = r_pc;
    assign pc_plus4_o = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, combinational imem address and the IF/ID register.
// Optional misaligned-target fault is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_fault_o
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_access_fault;
    logic        w_misalign_fault;
    logic        w_fault;
    ifid_t       w_capture;
    ifid_t       r_ifid;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (w_pc),
        .pc_plus4_o       (w_pc_plus4)
    );

    assign inst_addr_o    = w_pc;
    assign w_access_fault = (w_pc >= IMEM_LIMIT);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign_fault = (w_pc[1:0] != 2'b00);
`else
    assign w_misalign_fault = 1'b0;
`endif

    assign w_fault = w_access_fault | w_misalign_fault;

    // A faulting fetch still occupies a valid slot so the trap is raised downstream.
    always_comb begin
        w_capture.valid    = 1'b1;
        w_capture.instr    = w_fault ? NOP : inst_data_i;
        w_capture.pc       = w_pc;
        w_capture.pc_plus4 = w_pc_plus4;
        w_capture.fault    = w_fault;
    end

    // Priority: reset, redirect (beats stall), stall hold, capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid <= IFID_BUBBLE;
        end else if (redirect_valid_i) begin
            r_ifid <= IFID_BUBBLE;
        end else if (!stall_i) begin
            r_ifid <= w_capture;
        end
    end

    assign ifid_valid_o    = r_ifid.valid;
    assign ifid_instr_o    = r_ifid.instr;
    assign ifid_pc_o       = r_ifid.pc;
    assign ifid_pc_plus4_o = r_ifid.pc_plus4;
    assign ifid_fault_o    = r_ifid.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequence plus randomized stall/redirect/reset
// traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W      = 32'h0000_0013;
    localparam logic [31:0] RST_PC     = 32'h0000_0000;
    localparam int          IMEM_BYTES = 4096;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic        ifid_fault_o;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_addr_o      (inst_addr_o),
        .inst_data_i      (inst_data_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_pc_plus4_o  (ifid_pc_plus4_o),
        .ifid_fault_o     (ifid_fault_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- instruction memory (address-derived words) ----------------
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign inst_data_i = imem_word(inst_addr_o);

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the next fetch address and what the IF/ID slot must contain.
    logic [31:0] m_fetch   = RST_PC;
    logic        m_valid   = 1'b0;
    logic [31:0] m_instr   = NOP_W;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_pc4     = 32'h0;
    logic        m_fault   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fetch = RST_PC;
            m_valid = 1'b0; m_instr = NOP_W; m_pc = 32'h0; m_pc4 = 32'h0; m_fault = 1'b0;
        end else if (redirect_valid_i) begin
            m_fetch = TRAP_EN ? redirect_pc_i : {redirect_pc_i[31:2], 2'b00};
            m_valid = 1'b0; m_instr = NOP_W; m_fault = 1'b0;
        end else if (!stall_i) begin
            m_fault = (m_fetch >= IMEM_BYTES) || (TRAP_EN && (m_fetch % 4 != 0));
            m_valid = 1'b1;
            m_instr = m_fault ? NOP_W : imem_word(m_fetch);
            m_pc    = m_fetch;
            m_pc4   = m_fetch + 32'd4;
            m_fetch = m_fetch + 32'd4;
        end
    end

    // ---------------- per-cycle compare against model ----------------
    always @(posedge clk) begin
        #1;
        check("cmp_inst_addr", inst_addr_o, m_fetch);
        check("cmp_valid", 32'(ifid_valid_o), 32'(m_valid));
        check("cmp_instr", ifid_instr_o, m_instr);
        check("cmp_fault", 32'(ifid_fault_o), 32'(m_fault));
        if (m_valid || rst) begin
            check("cmp_pc", ifid_pc_o, m_pc);
            check("cmp_pc_plus4", ifid_pc_plus4_o, m_pc4);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"}, inst_addr_o, RST_PC);
        check({tag, "_valid"}, 32'(ifid_valid_o), 32'd0);
        check({tag, "_instr"}, ifid_instr_o, NOP_W);
        check({tag, "_pc"}, ifid_pc_o, 32'h0);
        check({tag, "_pc4"}, ifid_pc_plus4_o, 32'h0);
        check({tag, "_fault"}, 32'(ifid_fault_o), 32'd0);
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr, input logic f);
        check({tag, "_valid"}, 32'(ifid_valid_o), 32'(v));
        check({tag, "_pc"}, ifid_pc_o, pc);
        check({tag, "_pc4"}, ifid_pc_plus4_o, pc + 32'd4);
        check({tag, "_instr"}, ifid_instr_o, instr);
        check({tag, "_fault"}, 32'(ifid_fault_o), 32'(f));
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic stall);
        @(negedge clk);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        stall_i          = stall;
        tick();
        @(negedge clk);
        redirect_valid_i = 1'b0;
        stall_i          = 1'b0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: return 32'(IMEM_BYTES) - 32'd8 + {30'h0, r[1:0]};
            1: return {20'h0, r[11:0]};
            2: return 32'hFFFF_FFF8 | {30'h0, r[1:0]};
            3: return r;
            4: return 32'h0000_0040 | {30'h0, r[1:0]};
            default: return {20'h0, r[11:2], 2'b00};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #1 check_reset_vals("rst_init");

        // Reset release, sequential fetch.
        @(negedge clk);
        rst = 1'b0;
        check("rel_addr0", inst_addr_o, 32'h0);
        tick();
        check("seq_addr4", inst_addr_o, 32'h4);
        check_ifid("seq0", 1'b1, 32'h0, 32'h5A5A_0F0F, 1'b0);
        tick();
        check("seq_addr8", inst_addr_o, 32'h8);
        check_ifid("seq4", 1'b1, 32'h4, imem_word(32'h4), 1'b0);

        // Stall three cycles at PC 8.
        @(negedge clk);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", inst_addr_o, 32'h8);
            check_ifid("stall_hold", 1'b1, 32'h4, imem_word(32'h4), 1'b0);
        end
        @(negedge clk);
        stall_i = 1'b0;
        tick();
        check_ifid("rel8", 1'b1, 32'h8, imem_word(32'h8), 1'b0);
        check("rel_addrC", inst_addr_o, 32'hC);
        tick();
        check_ifid("relC", 1'b1, 32'hC, imem_word(32'hC), 1'b0);

        // Redirect overriding a stall.
        redirect_to(32'h40, 1'b1);
        check("redir_addr40", inst_addr_o, 32'h40);
        check("redir_bubble_valid", 32'(ifid_valid_o), 32'd0);
        check("redir_bubble_instr", ifid_instr_o, NOP_W);
        tick();
        check_ifid("redir40", 1'b1, 32'h40, imem_word(32'h40), 1'b0);

        // Top of instruction memory and access fault.
        redirect_to(32'hFFC, 1'b0);
        tick();
        check_ifid("top_ffc", 1'b1, 32'hFFC, imem_word(32'hFFC), 1'b0);
        tick();
        check_ifid("acc_1000", 1'b1, 32'h1000, NOP_W, 1'b1);

        // Misaligned redirect target.
        redirect_to(32'h42, 1'b0);
        tick();
        if (TRAP_EN) check_ifid("mis42", 1'b1, 32'h42, NOP_W, 1'b1);
        else         check_ifid("mis42", 1'b1, 32'h40, imem_word(32'h40), 1'b0);

        // 32-bit wrap from the last word address.
        redirect_to(32'hFFFF_FFFC, 1'b0);
        tick();
        check_ifid("wrap_top", 1'b1, 32'hFFFF_FFFC, NOP_W, 1'b1);
        check("wrap_addr0", inst_addr_o, 32'h0);
        tick();
        check_ifid("wrap_zero", 1'b1, 32'h0, imem_word(32'h0), 1'b0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_ifid("post_rst", 1'b1, RST_PC, imem_word(RST_PC), 1'b0);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst              = ($urandom_range(0, 99) == 0);
            stall_i          = ($urandom_range(0, 3) == 0);
            redirect_valid_i = ($urandom_range(0, 6) == 0);
            redirect_pc_i    = pick_target();
        end
        @(negedge clk);
        rst = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
